// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-flop sync, debounce to a registered level and one-cycle press pulse.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add auto-repeat pulses while a button stays held.
module button_debounce #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 251250,
  parameter int REPEAT_DELAY    = 12562500,
  parameter int REPEAT_PERIOD   = 2512500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] pressed,
  output logic [N-1:0] press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RM = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RM) + 1;
`endif
  logic [N-1:0] s1, s2, sync;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= btn_n;
      s2 <= s1;
    end
  end
  assign sync = ~s2;
  for (genvar i = 0; i < N; i++) begin : g
    logic [CW-1:0] cnt;
    logic p, pp, accept, rep;
    assign accept = sync[i] != p && cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
        p   <= 1'b0;
        pp  <= 1'b0;
      end else begin
        cnt <= (sync[i] == p || accept) ? '0 : cnt + 1'b1;
        p   <= accept ? sync[i] : p;
        pp  <= (accept && sync[i]) || rep;
      end
    end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    logic [RW-1:0] rcnt;
    logic first;
    // a release accepted this cycle wins over a repeat falling due
    assign rep = p && !accept && rcnt == (first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
    always_ff @(posedge clk) begin
      if (!rst_n || !p || accept) begin
        rcnt  <= '0;
        first <= 1'b1;
      end else if (rep) begin
        rcnt  <= '0;
        first <= 1'b0;
      end else begin
        rcnt  <= rcnt + 1'b1;
      end
    end
`else
    // repeat timing has no effect here; the expression keeps the parameters referenced
    assign rep = REPEAT_DELAY < 0 && REPEAT_PERIOD < 0;
`endif
    assign pressed[i]     = p;
    assign press_pulse[i] = pp;
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed stimulus pushes expected output changes; a negedge monitor pops and compares.
module tb_button_debounce;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] pressed, press_pulse;
  int cyc = 0, checks = 0, fails = 0;
  bit mon_en = 1'b0;
  logic [3:0] prev = '0;
  typedef struct {int c; logic [1:0] p; logic [1:0] pp;} ev_t;
  ev_t q[$];

  button_debounce #(.N(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .pressed(pressed), .press_pulse(press_pulse));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] pp);
    q.push_back('{c, p, pp});
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (pressed !== 2'b00 || press_pulse !== 2'b00) begin
      fails++;
      $display("FAIL %s: pressed=%b pulse=%b, required pressed=00 pulse=00", name, pressed, press_pulse);
    end
  endtask

  // every change of the outputs must match the next queued expectation
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && {pressed, press_pulse} !== prev) begin
      prev = {pressed, press_pulse};
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: cyc=%0d pressed=%b pulse=%b, required no change", cyc, pressed, press_pulse);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.p !== pressed || e.pp !== press_pulse) begin
          fails++;
          $display("FAIL event: got cyc=%0d pressed=%b pulse=%b, required cyc=%0d pressed=%b pulse=%b",
                   cyc, pressed, press_pulse, e.c, e.p, e.pp);
        end
      end
    end
  end

  initial begin
    int c, p0;
    wait_n(3);
    check_zero("reset_init");
    rst_n = 1'b1;
    wait_n(3);
    mon_en = 1'b1;
    // clean press then release; the repeat due at release is suppressed
    c = cyc;
    btn_n = 2'b10;
    push(c + 6, 2'b01, 2'b01);
    push(c + 7, 2'b01, 2'b00);
    wait_n(10);
    btn_n = 2'b11;
    push(c + 16, 2'b00, 2'b00);
    wait_n(10);
    // bounce on ch0 plus a one-cycle glitch on ch1
    c = cyc;
    btn_n = 2'b00;
    wait_n(1);
    btn_n = 2'b10;
    wait_n(2);
    btn_n = 2'b11;
    wait_n(1);
    btn_n = 2'b10;
    push(c + 10, 2'b01, 2'b01);
    push(c + 11, 2'b01, 2'b00);
    wait_n(8);
    btn_n = 2'b11;
    push(c + 18, 2'b00, 2'b00);
    wait_n(10);
    // simultaneous press on both channels
    c = cyc;
    btn_n = 2'b00;
    push(c + 6, 2'b11, 2'b11);
    push(c + 7, 2'b11, 2'b00);
    wait_n(8);
    btn_n = 2'b11;
    push(c + 14, 2'b00, 2'b00);
    wait_n(10);
    // reset mid-qualification, then long hold
    c = cyc;
    btn_n = 2'b10;
    wait_n(2);
    rst_n = 1'b0;
    wait_n(1);
    check_zero("reset_mid_qual");
    rst_n = 1'b1;
    p0 = c + 9;
    push(p0, 2'b01, 2'b01);
    push(p0 + 1, 2'b01, 2'b00);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    for (int o = 10; o <= 35; o += 3) begin
      push(p0 + o, 2'b01, 2'b01);
      push(p0 + o + 1, 2'b01, 2'b00);
    end
`endif
    push(p0 + 36, 2'b00, 2'b00);
    wait_n(36);
    btn_n = 2'b11;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    wait_n(20);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
